// File: rtl/contador_pkg.sv
// Shared definitions for the per-queue counter bank and its sweep controller.
package contador_pkg;

  localparam int NUM_CNT_DEF = 5;
  localparam int CNT_W_DEF   = 5;
  localparam int IDX_W_DEF   = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_IDLE = 2'd1,
    ST_SELECT    = 2'd2,
    ST_CAPTURE   = 2'd3
  } state_t;

endpackage

// File: rtl/contador_sweep_ctrl_wait_timer.sv
// Wait-for-idle timer: counts enabled cycles since the last clear and flags
// the cycle in which the TIMEOUT-th enabled cycle is reached (TIMEOUT=0 never expires).
module wait_timer #(
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam logic [TO_W-1:0] LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] count_q, count_d;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned and a latch is never inferred.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + TO_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = (TIMEOUT != 0) && enable_i && (count_q == LAST);

endmodule

// File: rtl/contador_sweep_ctrl.sv
// Sweep controller: waits for the counter bank to go quiet, then reads out every
// counter in index order as a stream of {rd_idx, rd_data} records.
module contador_sweep_ctrl
  import contador_pkg::*;
#(
  parameter int NUM_CNT = NUM_CNT_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int IDX_W   = IDX_W_DEF,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             idle,
  input  logic [CNT_W-1:0] cuenta,
  output logic [IDX_W-1:0] idx,
  output logic             cnt_req,
  output logic             rd_valid,
  output logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             err_to
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CNT - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             done_q, done_d;
  logic             err_to_q, err_to_d;
  logic             expire;

  // Timer restarts from zero on every entry into WAIT_IDLE.
  wait_timer #(
    .TO_W   (TO_W),
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear_i (state_q != ST_WAIT_IDLE),
    .enable_i(state_q == ST_WAIT_IDLE),
    .expire_o(expire)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rd_idx_d   = rd_idx_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    err_to_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          idx_d   = '0;
          state_d = idle ? ST_SELECT : ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        // A late idle still beats an expiring timer in the same cycle.
        if (idle) begin
          state_d = ST_SELECT;
        end else if (expire) begin
          state_d  = ST_IDLE;
          err_to_d = 1'b1;
        end
      end
      ST_SELECT: begin
        state_d = idle ? ST_CAPTURE : ST_WAIT_IDLE;
      end
      ST_CAPTURE: begin
        rd_valid_d = 1'b1;
        rd_idx_d   = idx_q;
        rd_data_d  = cuenta;
        if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_SELECT;
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      rd_idx_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rd_idx_q   <= rd_idx_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      err_to_q   <= err_to_d;
    end
  end

  assign idx      = idx_q;
  assign cnt_req  = (state_q == ST_SELECT);
  assign busy     = (state_q != ST_IDLE);
  assign rd_valid = rd_valid_q;
  assign rd_idx   = rd_idx_q;
  assign rd_data  = rd_data_q;
  assign done     = done_q;
  assign err_to   = err_to_q;

endmodule

// File: tb/tb_contador_sweep_ctrl.sv
// Scoreboard bench for contador_sweep_ctrl: stimulus pushes expected records and
// timeout events, an independent monitor pops and compares them as the DUT emits.
module tb_contador_sweep_ctrl;

  localparam int NUM_CNT = 5;
  localparam int CNT_W   = 5;
  localparam int IDX_W   = 3;
  localparam int TO_W    = 8;
  localparam int TIMEOUT = 16;

  typedef struct {
    int idx;
    int data;
    bit done;
    int cyc;   // -1 when the arrival cycle is not predicted
  } rec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             req;
  logic             idle;
  logic [CNT_W-1:0] cuenta;
  logic [IDX_W-1:0] idx;
  logic             cnt_req;
  logic             rd_valid;
  logic [IDX_W-1:0] rd_idx;
  logic [CNT_W-1:0] rd_data;
  logic             busy;
  logic             done;
  logic             err_to;

  logic [CNT_W-1:0] bank [NUM_CNT];
  rec_t             exp_q [$];
  int               err_q [$];
  int               cyc = 0;
  int               pass_cnt = 0;
  int               total_cnt = 0;

  contador_sweep_ctrl #(
    .NUM_CNT(NUM_CNT),
    .CNT_W  (CNT_W),
    .IDX_W  (IDX_W),
    .TO_W   (TO_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .idle    (idle),
    .cuenta  (cuenta),
    .idx     (idx),
    .cnt_req (cnt_req),
    .rd_valid(rd_valid),
    .rd_idx  (rd_idx),
    .rd_data (rd_data),
    .busy    (busy),
    .done    (done),
    .err_to  (err_to)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Counter bank: count is valid only in the cycle after the strobe, garbage otherwise.
  always @(posedge clk) cuenta <= cnt_req ? bank[idx] : ~bank[idx];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_rec(input int i, input int c);
    rec_t r;
    r.idx  = i;
    r.data = int'(bank[i]);
    r.done = (i == NUM_CNT - 1);
    r.cyc  = c;
    exp_q.push_back(r);
  endtask

  // With idle held high, index i is reported 2i+3 cycles after the accepting edge.
  task automatic push_sweep(input int base);
    for (int i = 0; i < NUM_CNT; i++) push_rec(i, (base < 0) ? -1 : base + 2 * i + 3);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_idx"}, idx, 0);
    check({tag, "_cnt_req"}, cnt_req, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_rd_idx"}, rd_idx, 0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err_to"}, err_to, 0);
  endtask

  task automatic drain(input string name, input int bound);
    int n = 0;
    while ((exp_q.size() != 0 || err_q.size() != 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size() + err_q.size(), 0);
    exp_q.delete();
    err_q.delete();
  endtask

  // Monitor
  initial begin
    rec_t             r;
    int               e;
    logic [IDX_W-1:0] last_idx;
    logic [CNT_W-1:0] last_data;
    last_idx  = '0;
    last_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        last_idx  = '0;
        last_data = '0;
      end else begin
        if (rd_valid) begin
          check("rd_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            r = exp_q.pop_front();
            check("rd_idx", rd_idx, r.idx);
            check("rd_data", rd_data, r.data);
            check("rd_done", done, r.done);
            if (r.cyc >= 0) check("rd_cycle", cyc, r.cyc);
          end
          last_idx  = rd_idx;
          last_data = rd_data;
        end else begin
          check("rd_hold", {rd_idx, rd_data}, {last_idx, last_data});
          check("done_without_rd_valid", done, 0);
        end
        if (err_to) begin
          check("err_expected", err_q.size() != 0, 1);
          if (err_q.size() != 0) begin
            e = err_q.pop_front();
            check("err_cycle", cyc, e);
          end
        end
        if (cnt_req) begin
          check("sel_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check("sel_idx", idx, exp_q[0].idx);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    int t0;
    int strobes;
    int low_run;
    int n;
    reset = 1'b1;
    req   = 1'b0;
    idle  = 1'b1;
    for (int i = 0; i < NUM_CNT; i++) bank[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // 1: basic sweep with exact cycle timing and busy window
    bank[0] = 5'd3; bank[1] = 5'd0; bank[2] = 5'd7; bank[3] = 5'd1; bank[4] = 5'd31;
    t0 = cyc;
    push_sweep(t0);
    req = 1'b1;
    for (int r = 1; r <= 2 * NUM_CNT + 1; r++) begin
      @(negedge clk);
      if (r == 1) req = 1'b0;
      check("t1_busy", busy, (cyc - t0) <= 2 * NUM_CNT);
    end
    drain("t1_drain", 40);

    // 2: idle arrives 10 cycles after the request
    for (int i = 0; i < NUM_CNT; i++) bank[i] = CNT_W'($urandom);
    idle = 1'b0;
    t0 = cyc;
    push_sweep(t0 + 10);
    req = 1'b1;
    strobes = 0;
    for (int r = 1; r <= 10; r++) begin
      @(negedge clk);
      if (r == 1) req = 1'b0;
      strobes += int'(cnt_req);
      check("t2_busy_waiting", busy, 1);
      if (r == 10) idle = 1'b1;
    end
    check("t2_no_strobe_waiting", strobes, 0);
    drain("t2_drain", 40);

    // 3: idle drops across the SELECT of index 2 for 4 cycles
    for (int i = 0; i < NUM_CNT; i++) bank[i] = CNT_W'($urandom);
    t0 = cyc;
    push_rec(0, t0 + 3);
    push_rec(1, t0 + 5);
    for (int i = 2; i < NUM_CNT; i++) push_rec(i, t0 + 8 + 2 * (i - 2) + 3);
    req = 1'b1;
    for (int r = 1; r <= 8; r++) begin
      @(negedge clk);
      if (r == 1) req = 1'b0;
      if (r >= 5) check("t3_idx_hold", idx, 2);
      if (r == 4) idle = 1'b0;
      if (r == 8) idle = 1'b1;
    end
    drain("t3_drain", 40);

    // 4: idle never arrives -> timeout
    idle = 1'b0;
    t0 = cyc;
    err_q.push_back(t0 + TIMEOUT + 1);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    drain("t4_drain", 3 * TIMEOUT);
    check("t4_busy_after_abort", busy, 0);
    idle = 1'b1;
    @(negedge clk);

    // 5: reset in the cycle after rd_valid of index 1, then a clean sweep
    for (int i = 0; i < NUM_CNT; i++) bank[i] = CNT_W'($urandom);
    t0 = cyc;
    push_sweep(t0);
    req = 1'b1;
    for (int r = 1; r <= 6; r++) begin
      @(negedge clk);
      if (r == 1) req = 1'b0;
    end
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_outputs_zero("t5_after_reset");
    reset = 1'b0;
    @(negedge clk);
    t0 = cyc;
    push_sweep(t0);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    drain("t5_drain", 40);

    // 6: req while busy is dropped; req in the done cycle starts a new sweep
    for (int i = 0; i < NUM_CNT; i++) bank[i] = CNT_W'($urandom);
    t0 = cyc;
    push_sweep(t0);
    push_sweep(t0 + 2 * NUM_CNT + 1);
    req = 1'b1;
    for (int r = 1; r <= 2 * NUM_CNT + 1; r++) begin
      @(negedge clk);
      req = (r == 4) || (r == 2 * NUM_CNT + 1);
    end
    @(negedge clk);
    req = 1'b0;
    drain("t6_drain", 60);

    // 7: random bank contents with random short idle dropouts
    low_run = 0;
    for (int s = 0; s < 20; s++) begin
      for (int i = 0; i < NUM_CNT; i++) bank[i] = CNT_W'($urandom);
      idle    = 1'($urandom_range(0, 1));
      low_run = idle ? 0 : 1;
      push_sweep(-1);
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
        if (low_run >= 3) idle = 1'b1;
        else idle = ($urandom_range(0, 3) != 0);
        low_run = idle ? 0 : low_run + 1;
        @(negedge clk);
        n++;
      end
      idle = 1'b1;
      check("t7_drain", exp_q.size(), 0);
      exp_q.delete();
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
